// File: rtl/csr_exu_pipe.sv
// csr_exu_pipe: Zicsr execute stage with one registered, back-pressured output.
// Define CSR_EXU_IMM_EN to decode CSRRWI/CSRRSI/CSRRCI; otherwise they trap as illegal.
module csr_exu_pipe #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       func3,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [4:0]       rs1_idx,
  input  logic [4:0]       rd_addr,
  input  logic [11:0]      csr_addr,
  input  logic [XLEN-1:0]  csr_rdata,
  input  logic [1:0]       priv,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  rd_o,
  output logic [4:0]       rd_addr_o,
  output logic             rd_w_o,
  output logic [XLEN-1:0]  csr_o,
  output logic [11:0]      csr_a_o,
  output logic             csr_w_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] op_cnt_o
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t           state_q, state_d;
  logic             accept, hs;
  logic [XLEN-1:0]  src, new_val;
  logic             wr_try, ill, imm_bad;
  logic [XLEN-1:0]  rd_q, csr_q;
  logic [4:0]       rda_q;
  logic [11:0]      csra_q;
  logic             rdw_q, csrw_q, ill_q;
  logic [CNT_W-1:0] cnt_q;

  assign out_valid = (state_q == FULL);
  assign in_ready  = !flush && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign hs        = out_valid && out_ready && !flush;

`ifdef CSR_EXU_IMM_EN
  assign src     = func3[2] ? {{(XLEN-5){1'b0}}, rs1_idx}
                            : rs1_data;
  assign imm_bad = 1'b0;
`else
  assign src     = rs1_data;
  assign imm_bad = func3[2];
`endif

  always_comb begin
    new_val = '0;
    unique case (1'b1)
      (func3[1:0] == 2'b01): new_val = src;
      (func3[1:0] == 2'b10): new_val = csr_rdata | src;
      (func3[1:0] == 2'b11): new_val = csr_rdata & ~src;
      default:               new_val = '0;
    endcase
  end

  // Set/clear with rs1=x0 (or zimm=0) is a pure read.
  assign wr_try = (func3[1:0] == 2'b01)
               || (rs1_idx != 5'd0);

  assign ill = (func3[1:0] == 2'b00)
            || imm_bad
            || (wr_try && (csr_addr[11:10] == 2'b11))
            || (priv < csr_addr[9:8]);

  always_comb begin
    state_d = state_q;
    if (flush)          state_d = EMPTY;
    else if (accept)    state_d = FULL;
    else if (out_ready) state_d = EMPTY;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_q   <= '0;
      csr_q  <= '0;
      rda_q  <= '0;
      csra_q <= '0;
      rdw_q  <= 1'b0;
      csrw_q <= 1'b0;
      ill_q  <= 1'b0;
    end else if (accept) begin
      rd_q   <= ill ? '0 : csr_rdata;
      csr_q  <= ill ? '0 : new_val;
      rda_q  <= rd_addr;
      csra_q <= csr_addr;
      rdw_q  <= !ill && (rd_addr != 5'd0);
      csrw_q <= !ill && wr_try;
      ill_q  <= ill;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)              cnt_q <= '0;
    else if (hs && !ill_q)   cnt_q <= cnt_q + CNT_W'(1);
  end

  assign rd_o      = rd_q;
  assign csr_o     = csr_q;
  assign rd_addr_o = rda_q;
  assign csr_a_o   = csra_q;
  assign rd_w_o    = rdw_q & out_valid;
  assign csr_w_o   = csrw_q & out_valid;
  assign illegal_o = ill_q & out_valid;
  assign op_cnt_o  = cnt_q;

endmodule

// File: tb/tb_csr_exu_pipe.sv
// tb_csr_exu_pipe: directed and random checks of csr_exu_pipe
// against a transaction-level reference model.
module tb_csr_exu_pipe;
  localparam int XLEN = 64;
  localparam int CW   = 4;
  localparam int W    = CW + 150;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n, in_valid, in_ready, flush;
  logic            out_valid, out_ready;
  logic [2:0]      func3;
  logic [63:0]     rs1_data, csr_rdata, rd_o, csr_o;
  logic [4:0]      rs1_idx, rd_addr, rd_addr_o;
  logic [11:0]     csr_addr, csr_a_o;
  logic [1:0]      priv;
  logic            rd_w_o, csr_w_o, illegal_o;
  logic [CW-1:0]   op_cnt_o;

  csr_exu_pipe #(.XLEN(XLEN), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .func3(func3), .rs1_data(rs1_data),
    .rs1_idx(rs1_idx), .rd_addr(rd_addr),
    .csr_addr(csr_addr), .csr_rdata(csr_rdata),
    .priv(priv), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .rd_o(rd_o), .rd_addr_o(rd_addr_o),
    .rd_w_o(rd_w_o), .csr_o(csr_o),
    .csr_a_o(csr_a_o), .csr_w_o(csr_w_o),
    .illegal_o(illegal_o), .op_cnt_o(op_cnt_o)
  );

`ifdef CSR_EXU_IMM_EN
  localparam bit IMM = 1'b1;
`else
  localparam bit IMM = 1'b0;
`endif

  typedef struct packed {
    logic [63:0] rd;
    logic [63:0] csr;
    logic [4:0]  rda;
    logic [11:0] csra;
    logic        rdw;
    logic        csrw;
    logic        ill;
  } res_t;

  res_t          m;
  logic          m_valid;
  logic [CW-1:0] m_cnt;
  int            chk, err;

  function automatic res_t ref_op(
    logic [2:0] f3, logic [63:0] rs1,
    logic [4:0] idx, logic [4:0] rd,
    logic [11:0] a, logic [63:0] old,
    logic [1:0] pv);
    res_t r;
    logic [63:0] operand, nv;
    bit writes, legal;
    operand = f3[2] ? 64'(idx) : rs1;
    nv = 64'd0;
    if (f3[1:0] == 2'd1)      nv = operand;
    else if (f3[1:0] == 2'd2) nv = old | operand;
    else if (f3[1:0] == 2'd3) nv = old & ~operand;
    writes = (f3[1:0] == 2'd1) || (idx != 5'd0);
    legal  = (f3[1:0] != 2'd0)
          && (!f3[2] || IMM)
          && !(writes && a[11:10] == 2'b11)
          && (int'(pv) >= int'(a[9:8]));
    r.rda  = rd;
    r.csra = a;
    r.ill  = !legal;
    r.rd   = legal ? old : 64'd0;
    r.csr  = legal ? nv : 64'd0;
    r.rdw  = legal && (rd != 5'd0);
    r.csrw = legal && writes;
    return r;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m       <= '0;
      m_cnt   <= '0;
    end else begin
      if (m_valid && out_ready && !flush && !m.ill)
        m_cnt <= m_cnt + 1'b1;
      if (flush) m_valid <= 1'b0;
      else if (in_valid && (!m_valid || out_ready)) begin
        m_valid <= 1'b1;
        m <= ref_op(func3, rs1_data, rs1_idx, rd_addr,
                    csr_addr, csr_rdata, priv);
      end else if (out_ready) m_valid <= 1'b0;
    end
  end

  function automatic logic [W-1:0] exp_v();
    logic rdy;
    rdy = !flush && (!m_valid || out_ready);
    return {m_valid, m_valid & m.rdw, m_valid & m.csrw,
            m_valid & m.ill, m_cnt, rdy,
            m_valid ? {m.rd, m.rda, m.csr, m.csra} : 145'd0};
  endfunction

  function automatic logic [W-1:0] act_v();
    return {out_valid, rd_w_o, csr_w_o, illegal_o,
            op_cnt_o, in_ready,
            out_valid ? {rd_o, rd_addr_o, csr_o, csr_a_o}
                      : 145'd0};
  endfunction

  task automatic drive(logic [2:0] f3, logic [63:0] rs1,
                       logic [4:0] idx, logic [4:0] rd,
                       logic [11:0] a, logic [63:0] old,
                       logic [1:0] pv);
    in_valid  = 1'b1;
    func3     = f3;
    rs1_data  = rs1;
    rs1_idx   = idx;
    rd_addr   = rd;
    csr_addr  = a;
    csr_rdata = old;
    priv      = pv;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] r64();
    return {$urandom, $urandom};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    out_ready = 1'b1;
    drive(3'b001, r64(), 5'd1, 5'd3, 12'h340, r64(), 2'd3);
    cyc();
    cyc();
    rst_n = 1'b1;
    in_valid = 1'b0;
    #1;
    chk++;
    if ({out_valid, rd_w_o, csr_w_o, illegal_o} !== 4'b0
        || op_cnt_o !== '0 || rd_o !== '0 || csr_o !== '0
        || rd_addr_o !== '0 || csr_a_o !== '0) begin
      err++;
      $display("FAIL reset_outs act=%h", act_v());
    end
    chk++;
    if (in_ready !== 1'b1) begin
      err++;
      $display("FAIL reset_in_ready act=%b exp=1", in_ready);
    end
  endtask

  task automatic test_csrrw();
    out_ready = 1'b0;
    drive(3'b001, 64'h1234, 5'd1, 5'd5, 12'h340, 64'hAA, 2'd3);
    cyc();
    in_valid = 1'b0;
    chk++;
    if ({out_valid, rd_w_o, csr_w_o, illegal_o} !== 4'b1110) begin
      err++;
      $display("FAIL rw_flags act=%b exp=1110",
               {out_valid, rd_w_o, csr_w_o, illegal_o});
    end
    chk++;
    if (rd_o !== 64'hAA || csr_o !== 64'h1234
        || rd_addr_o !== 5'd5 || csr_a_o !== 12'h340) begin
      err++;
      $display("FAIL rw_data act=%h/%h/%h/%h",
               rd_o, csr_o, rd_addr_o, csr_a_o);
    end
    out_ready = 1'b1;
    cyc();
    chk++;
    if (op_cnt_o !== 4'd1 || out_valid !== 1'b0) begin
      err++;
      $display("FAIL rw_count act=%0d/%b exp=1/0",
               op_cnt_o, out_valid);
    end
  endtask

  task automatic test_set_clear();
    out_ready = 1'b1;
    drive(3'b010, r64(), 5'd0, 5'd7, 12'h340, 64'hF0, 2'd3);
    cyc();
    chk++;
    if (csr_w_o !== 1'b0 || rd_o !== 64'hF0 || out_valid !== 1'b1) begin
      err++;
      $display("FAIL rs_x0 act=%b/%h exp=0/f0", csr_w_o, rd_o);
    end
    drive(3'b011, 64'h30, 5'd3, 5'd7, 12'h340, 64'hF0, 2'd3);
    cyc();
    chk++;
    if (csr_o !== 64'hC0 || csr_w_o !== 1'b1) begin
      err++;
      $display("FAIL rc act=%h/%b exp=c0/1", csr_o, csr_w_o);
    end
    drive(3'b001, 64'h55, 5'd1, 5'd0, 12'h340, 64'h1, 2'd3);
    cyc();
    chk++;
    if (rd_w_o !== 1'b0 || csr_w_o !== 1'b1) begin
      err++;
      $display("FAIL rw_x0 act=%b/%b exp=0/1", rd_w_o, csr_w_o);
    end
    in_valid = 1'b0;
    cyc();
    chk++;
    if (act_v() !== exp_v()) begin
      err++;
      $display("FAIL sc_model act=%h exp=%h", act_v(), exp_v());
    end
  endtask

  task automatic test_illegal();
    logic [CW-1:0] c0;
    c0 = m_cnt;
    out_ready = 1'b1;
    drive(3'b001, r64(), 5'd2, 5'd9, 12'hF14, 64'h5, 2'd3);
    cyc();
    chk++;
    if ({illegal_o, rd_w_o, csr_w_o} !== 3'b100 || rd_o !== '0) begin
      err++;
      $display("FAIL ro_write act=%b/%h exp=100/0",
               {illegal_o, rd_w_o, csr_w_o}, rd_o);
    end
    in_valid = 1'b0;
    cyc();
    chk++;
    if (op_cnt_o !== c0) begin
      err++;
      $display("FAIL ill_count act=%0d exp=%0d", op_cnt_o, c0);
    end
    drive(3'b010, r64(), 5'd0, 5'd9, 12'hF14, 64'h77, 2'd3);
    cyc();
    chk++;
    if (illegal_o !== 1'b0 || rd_o !== 64'h77 || rd_w_o !== 1'b1) begin
      err++;
      $display("FAIL ro_read act=%b/%h exp=0/77", illegal_o, rd_o);
    end
    drive(3'b010, r64(), 5'd0, 5'd9, 12'h300, 64'h8, 2'd0);
    cyc();
    chk++;
    if (illegal_o !== 1'b1 || rd_w_o !== 1'b0) begin
      err++;
      $display("FAIL priv act=%b exp=1", illegal_o);
    end
    drive(3'b000, r64(), 5'd1, 5'd9, 12'h340, 64'h8, 2'd3);
    cyc();
    chk++;
    if (illegal_o !== 1'b1 || csr_w_o !== 1'b0) begin
      err++;
      $display("FAIL f3_zero act=%b exp=1", illegal_o);
    end
    in_valid = 1'b0;
    cyc();
  endtask

  task automatic test_backpressure();
    logic [CW-1:0] c0;
    out_ready = 1'b0;
    drive(3'b001, 64'hA0, 5'd1, 5'd4, 12'h340, 64'h10, 2'd3);
    cyc();
    c0 = m_cnt;
    for (int i = 0; i < 3; i++) begin
      drive(3'b001, 64'hBB, 5'd1, 5'd6, 12'h341, 64'h20, 2'd3);
      cyc();
      chk++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || rd_o !== 64'h10
          || csr_o !== 64'hA0 || rd_addr_o !== 5'd4) begin
        err++;
        $display("FAIL stall%0d act=%b/%h/%h", i,
                 in_ready, rd_o, csr_o);
      end
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(3'b001, 64'hC0 + 64'(i), 5'd1, 5'd8, 12'h340,
            64'h30 + 64'(i), 2'd3);
      cyc();
      chk++;
      if (out_valid !== 1'b1 || rd_o !== 64'h30 + 64'(i)) begin
        err++;
        $display("FAIL b2b%0d act=%b/%h exp=1/%h", i,
                 out_valid, rd_o, 64'h30 + 64'(i));
      end
    end
    chk++;
    if (op_cnt_o !== CW'(c0 + 4)) begin
      err++;
      $display("FAIL b2b_count act=%0d exp=%0d",
               op_cnt_o, CW'(c0 + 4));
    end
    in_valid = 1'b0;
    cyc();
  endtask

  task automatic test_flush();
    logic [CW-1:0] c0;
    out_ready = 1'b0;
    drive(3'b001, 64'h9, 5'd1, 5'd2, 12'h340, 64'h3, 2'd3);
    cyc();
    c0 = m_cnt;
    flush = 1'b1;
    out_ready = 1'b1;
    drive(3'b001, 64'hE, 5'd1, 5'd3, 12'h340, 64'h4, 2'd3);
    #1;
    chk++;
    if (in_ready !== 1'b0) begin
      err++;
      $display("FAIL flush_rdy act=%b exp=0", in_ready);
    end
    cyc();
    flush = 1'b0;
    in_valid = 1'b0;
    chk++;
    if ({out_valid, rd_w_o, csr_w_o, illegal_o} !== 4'b0
        || op_cnt_o !== c0) begin
      err++;
      $display("FAIL flush act=%b/%0d exp=0000/%0d",
               {out_valid, rd_w_o, csr_w_o, illegal_o}, op_cnt_o, c0);
    end
    cyc();
    chk++;
    if (out_valid !== 1'b0 || op_cnt_o !== c0) begin
      err++;
      $display("FAIL flush_after act=%b/%0d", out_valid, op_cnt_o);
    end
  endtask

  task automatic test_reset_full();
    out_ready = 1'b0;
    drive(3'b001, 64'h9, 5'd1, 5'd2, 12'h340, 64'h3, 2'd3);
    cyc();
    rst_n = 1'b0;
    in_valid = 1'b0;
    cyc();
    rst_n = 1'b1;
    chk++;
    if (out_valid !== 1'b0 || op_cnt_o !== '0) begin
      err++;
      $display("FAIL reset_full act=%b/%0d exp=0/0",
               out_valid, op_cnt_o);
    end
  endtask

  task automatic test_imm();
    out_ready = 1'b1;
    drive(3'b110, r64(), 5'h1F, 5'd3, 12'h340, 64'h100, 2'd3);
    cyc();
    in_valid = 1'b0;
    chk++;
`ifdef CSR_EXU_IMM_EN
    if (csr_o !== 64'h11F || illegal_o !== 1'b0 || csr_w_o !== 1'b1) begin
      err++;
      $display("FAIL csrrsi act=%h/%b exp=11f/0", csr_o, illegal_o);
    end
`else
    if (illegal_o !== 1'b1 || csr_w_o !== 1'b0 || rd_w_o !== 1'b0) begin
      err++;
      $display("FAIL csrrsi_off act=%b exp=1", illegal_o);
    end
`endif
    cyc();
  endtask

  task automatic test_random();
    logic [11:0] addrs [6];
    addrs = '{12'hF14, 12'h340, 12'h300, 12'h100, 12'hC00, 12'h000};
    for (int i = 0; i < 600; i++) begin
      rst_n     = ($urandom_range(0, 99) != 0);
      flush     = ($urandom_range(0, 11) == 0);
      out_ready = $urandom_range(0, 3) != 0;
      drive(3'($urandom), r64(),
            ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
            5'($urandom),
            ($urandom_range(0, 2) == 0) ? 12'($urandom)
                                        : addrs[$urandom_range(0, 5)],
            r64(), 2'($urandom));
      in_valid = $urandom_range(0, 3) != 0;
      cyc();
      chk++;
      if (act_v() !== exp_v()) begin
        err++;
        $display("FAIL rand%0d act=%h exp=%h", i, act_v(), exp_v());
      end
    end
    rst_n = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    cyc();
  endtask

  initial begin
    chk = 0;
    err = 0;
    rst_n = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    drive(3'b000, 64'd0, 5'd0, 5'd0, 12'd0, 64'd0, 2'd0);
    in_valid = 1'b0;
    test_reset();
    test_csrrw();
    test_set_clear();
    test_illegal();
    test_backpressure();
    test_flush();
    test_reset_full();
    test_imm();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", chk, err);
    $finish;
  end
endmodule

// File: doc/csr_exu_pipe.md
Name: csr_exu_pipe

Overview:
- Parametrised CSR execute stage for the Zicsr instructions CSRRW/CSRRS/CSRRC and their immediate forms.
- Sits between decode/regfile read and the CSR file/writeback.
- Adds valid/ready handshakes, RISC-V write-suppression rules, illegal-access detection, flush, and a retired-op counter.
- Output is one registered stage with back-pressure.

Parameters:
- XLEN, 64, datapath width of rs1, CSR and rd values.
- CNT_W, 32, width of the retired-CSR-op counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  operation offered
- in_ready  out  1  stage can accept operation
- func3  in  3  instruction funct3
- rs1_data  in  XLEN  rs1 register value
- rs1_idx  in  5  rs1 index; also zimm for immediate forms
- rd_addr  in  5  destination register
- csr_addr  in  12  CSR address
- csr_rdata  in  XLEN  current CSR value
- priv  in  2  current privilege (0=U, 1=S, 3=M)
- flush  in  1  kill held result
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- rd_o  out  XLEN  value for rd
- rd_addr_o  out  5  rd index
- rd_w_o  out  1  rd write enable
- csr_o  out  XLEN  new CSR value
- csr_a_o  out  12  CSR address
- csr_w_o  out  1  CSR write enable
- illegal_o  out  1  illegal-instruction flag
- op_cnt_o  out  CNT_W  count of completed non-illegal ops

Behaviour:
- Reset (rst_n=0 at posedge clk): all outputs 0, including out_valid, illegal_o and op_cnt_o. in_ready is 1 in the cycle after reset.
- States:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- in_ready = !out_valid || out_ready. This is combinational and allows full throughput.
- Accept occurs when in_valid && in_ready. The result registers load at that posedge, giving latency 1.
  - EMPTY -> FULL on accept.
  - FULL -> FULL on accept with out_ready.
  - FULL -> EMPTY on out_ready without accept.
  - FULL holds all outputs stable while out_ready=0.
- Source operand: src = func3[2] ? zero-extend(rs1_idx) to XLEN : rs1_data.
- New CSR value:
  - func3[1:0]=01: csr_o = src.
  - func3[1:0]=10: csr_o = csr_rdata | src.
  - func3[1:0]=11: csr_o = csr_rdata & ~src.
- rd_o = csr_rdata, the old value, for every legal op.
- rd_w_o = legal && (rd_addr != 0).
- csr_w_o:
  - CSRRW/CSRRWI: 1 when legal.
  - CSRRS/CSRRC and immediate forms: 1 only when legal and rs1_idx != 0. The rs1_data value does not matter.
- Illegal if any of the following holds:
  - func3[1:0] = 00;
  - a write is attempted and csr_addr[11:10] = 2'b11 (read-only CSR);
  - priv < csr_addr[9:8].
- On illegal: illegal_o=1, rd_w_o=0, csr_w_o=0, rd_o=0, csr_o=0. rd_addr_o and csr_a_o are still captured.
- Write enables and illegal_o are qualified by out_valid. Consumers act only on out_valid && out_ready, exactly once per op.
- op_cnt_o increments by 1 on each out_valid && out_ready with illegal_o=0. It wraps modulo 2^CNT_W with no saturation.
- flush:
  - Same cycle: forces in_ready=0 and blocks accept.
  - Next state: EMPTY, with out_valid=0, rd_w_o=0, csr_w_o=0, illegal_o=0.
  - A flushed op is never counted.
  - Flush together with out_ready: the handshake does not count.
- Reset during FULL discards the held op. op_cnt_o returns to 0.

Optional Feature:
- Macro CSR_EXU_IMM_EN.
- Defined: immediate forms (func3 = 101/110/111) are decoded as above.
- Undefined: any func3[2]=1 sets illegal_o=1 and both write enables to 0. Immediate-forms-disabled logic and the zimm mux are not present.

Test Plan:
1. Reset, then CSRRW with rs1_data=0x1234, csr_rdata=0xAA, rd=5, csr_addr=0x340, priv=3 -> next cycle: out_valid=1, rd_o=0xAA, csr_o=0x1234, rd_w_o=1, csr_w_o=1, illegal_o=0, rd_addr_o=5, csr_a_o=0x340. After out_ready: op_cnt_o=1.
2. CSRRS with rs1_idx=0, csr_rdata=0xF0 -> csr_w_o=0, rd_o=0xF0. CSRRC with rs1_data=0x30, rs1_idx=3, csr_rdata=0xF0 -> csr_o=0xC0, csr_w_o=1. CSRRW with rd=0 -> rd_w_o=0.
3. Writes to csr_addr=0xF14 with priv=3 -> illegal_o=1, both write enables 0, op_cnt_o unchanged. CSRRS with rs1_idx=0 to 0xF14 -> legal, rd_o=csr_rdata. Access to 0x300 with priv=0 -> illegal_o=1.
4. Back-pressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and outputs stable. Then out_ready=1 for 4 back-to-back ops -> one result per cycle, op_cnt_o increases by 4.
5. flush while FULL with out_ready=1 -> next cycle out_valid=0, op_cnt_o unchanged. Same-cycle in_valid is not accepted.
6. With CSR_EXU_IMM_EN defined: CSRRSI with zimm=0x1F, csr_rdata=0x100 -> csr_o=0x11F. Without the macro: the same op gives illegal_o=1.
